// File: rtl/writeback_regfile.sv
// writeback_regfile: writeback source select plus 32-entry register file with write-to-read bypass
module writeback_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  MUX3_select,
  input  logic                  regwrite_enable,
  input  logic [DATA_WIDTH-1:0] ALU_out,
  input  logic [DATA_WIDTH-1:0] read_data,
  input  logic [ADDR_WIDTH-1:0] rd,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  output logic [DATA_WIDTH-1:0] rs1_data,
  output logic [DATA_WIDTH-1:0] rs2_data,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic [ADDR_WIDTH-1:0] wb_rd,
  output logic                  wb_valid
);
  localparam int NREG = 1 << ADDR_WIDTH;
  logic [DATA_WIDTH-1:0] regs_q [NREG];
  always_comb begin
    wb_data  = MUX3_select ? read_data : ALU_out;
    wb_rd    = rd;
    wb_valid = regwrite_enable && (rd != '0) && !RESET;
  end
  // Entry 0 is cleared by reset and never written, so it stays zero
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (wb_valid) begin
      regs_q[rd] <= wb_data;
    end
  end
  // Bypass the in-flight write so decode sees it in the same cycle
  always_comb begin
    rs1_data = RESET ? '0 : (wb_valid && rs1_addr == rd) ? wb_data : (rs1_addr == '0) ? '0 : regs_q[rs1_addr];
    rs2_data = RESET ? '0 : (wb_valid && rs2_addr == rd) ? wb_data : (rs2_addr == '0) ? '0 : regs_q[rs2_addr];
  end
endmodule

// File: tb/tb_writeback_regfile.sv
// tb_writeback_regfile: randomized scoreboard bench for writeback_regfile
module tb_writeback_regfile;
  logic        CLK;
  logic        RESET;
  logic        MUX3_select;
  logic        regwrite_enable;
  logic [31:0] ALU_out;
  logic [31:0] read_data;
  logic [4:0]  rd;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_valid;

  writeback_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .CLK(CLK), .RESET(RESET), .MUX3_select(MUX3_select), .regwrite_enable(regwrite_enable),
    .ALU_out(ALU_out), .read_data(read_data), .rd(rd), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .wb_data(wb_data), .wb_rd(wb_rd), .wb_valid(wb_valid)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    int          id;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] wbd;
    logic [4:0]  wbr;
    logic        wbv;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] mem [32];
  int          n_vec = 0;
  int          n_bad = 0;
  int          n_id  = 0;

  // Architectural view: the register state after this cycle's commit is what
  // decode should see now (0-cycle read-after-write); x0 is never written.
  task automatic drive(input logic rst, input logic sel, input logic en,
                       input logic [31:0] alu, input logic [31:0] ld,
                       input logic [4:0] d, input logic [4:0] a1, input logic [4:0] a2);
    logic [31:0] nxt [32];
    logic [31:0] wb;
    exp_t e;
    @(posedge CLK);
    #1;
    RESET = rst; MUX3_select = sel; regwrite_enable = en;
    ALU_out = alu; read_data = ld; rd = d; rs1_addr = a1; rs2_addr = a2;
    wb = sel ? ld : alu;
    nxt = mem;
    if (rst) begin
      for (int i = 0; i < 32; i++) nxt[i] = 32'h0;
    end else if (en && d != 5'd0) begin
      nxt[d] = wb;
    end
    e.id  = n_id;
    e.rs1 = rst ? 32'h0 : nxt[a1];
    e.rs2 = rst ? 32'h0 : nxt[a2];
    e.wbd = wb;
    e.wbr = d;
    e.wbv = en && (d != 5'd0) && !rst;
    sb_q.push_back(e);
    n_id++;
    mem = nxt;
  endtask

  task automatic rd_pair(input logic [4:0] a1, input logic [4:0] a2);
    drive(1'b0, 1'($urandom), 1'b0, $urandom, $urandom, 5'($urandom), a1, a2);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        n_vec++;
        if (rs1_data !== e.rs1 || rs2_data !== e.rs2 || wb_data !== e.wbd ||
            wb_rd !== e.wbr || wb_valid !== e.wbv) begin
          n_bad++;
          $display("FAIL vec%0d: got rs1=%h rs2=%h wb_data=%h wb_rd=%0d wb_valid=%b, expected rs1=%h rs2=%h wb_data=%h wb_rd=%0d wb_valid=%b",
                   e.id, rs1_data, rs2_data, wb_data, wb_rd, wb_valid, e.rs1, e.rs2, e.wbd, e.wbr, e.wbv);
        end
      end
    end
  end

  initial begin : stim
    logic [4:0] d;
    RESET = 1'b1; MUX3_select = 1'b0; regwrite_enable = 1'b0;
    ALU_out = '0; read_data = '0; rd = '0; rs1_addr = '0; rs2_addr = '0;
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    drive(1'b1, 1'b0, 1'b1, 32'h1, 32'h2, 5'd4, 5'd4, 5'd0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd1, 5'd2);
    // source select
    drive(1'b0, 1'b0, 1'b1, 32'h1234_5678, 32'hDEAD_BEEF, 5'd3, 5'd3, 5'd0);
    rd_pair(5'd3, 5'd3);
    drive(1'b0, 1'b1, 1'b1, 32'h1234_5678, 32'hDEAD_BEEF, 5'd3, 5'd0, 5'd3);
    rd_pair(5'd3, 5'd0);
    // x0 write attempt
    drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0, 5'd0, 5'd0, 5'd0);
    rd_pair(5'd0, 5'd0);
    // bypass
    drive(1'b0, 1'b0, 1'b1, 32'h11, 32'h0, 5'd7, 5'd1, 5'd2);
    drive(1'b0, 1'b1, 1'b1, 32'h0, 32'h22, 5'd7, 5'd7, 5'd7);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd7, 5'd7, 5'd7);
    // disabled write
    drive(1'b0, 1'b0, 1'b1, 32'h55, 32'h0, 5'd9, 5'd0, 5'd0);
    drive(1'b0, 1'b0, 1'b0, 32'hAAAA, 32'h0, 5'd9, 5'd9, 5'd9);
    // back-to-back same rd
    drive(1'b0, 1'b0, 1'b1, 32'hA1, 32'h0, 5'd12, 5'd12, 5'd0);
    drive(1'b0, 1'b0, 1'b1, 32'hA2, 32'h0, 5'd12, 5'd12, 5'd12);
    rd_pair(5'd12, 5'd0);
    // sweep
    for (int i = 1; i < 32; i++)
      drive(1'b0, 1'b0, 1'b1, i * 32'h0101_0101, $urandom, 5'(i), 5'($urandom), 5'(i));
    for (int i = 0; i < 32; i++) rd_pair(5'(i), 5'(31 - i));
    // reset after random writes, with a write to x5 in the reset cycle
    for (int i = 0; i < 10; i++)
      drive(1'b0, 1'($urandom), 1'b1, $urandom, $urandom, 5'($urandom), 5'($urandom), 5'($urandom));
    drive(1'b1, 1'b0, 1'b1, 32'h5555, 32'h0, 5'd5, 5'd5, 5'd5);
    for (int i = 1; i < 32; i += 2) rd_pair(5'(i), 5'((i + 1) % 32));
    // randomized traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      d = 5'($urandom);
      drive($urandom_range(0, 39) == 0, 1'($urandom), $urandom_range(0, 3) != 0, $urandom, $urandom, d,
            ($urandom_range(0, 2) == 0) ? d : 5'($urandom),
            ($urandom_range(0, 2) == 0) ? d : 5'($urandom));
    end
    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge CLK);
    #1;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d vectors left unchecked, expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
